// File: rtl/wb_arbiter.sv
// Purpose: shares one register-file write port between ALU and load writebacks and tracks in-flight destinations.
// Latency: a transfer on edge N drives reg_write/wr_rd/wr_data during cycle N+1; pending clears on the commit edge.
// Backpressure: the loser of a collision sees ready low and must hold rd/data; nothing unaccepted is captured here.
module wb_arbiter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            reg_write,
    output logic [4:0]      wr_rd,
    output logic [XLEN-1:0] wr_data,
    output logic [31:0]     pending
);

    // Priority pointer: 0 favours MEM, 1 favours ALU on a collision.
    logic            prio_q;
    logic            xfer;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [31:0]     pending_nxt;

    // Grants are purely combinational so a lone requester goes through in the same cycle.
    // Gating with reset_n keeps both readies low while the block is held in reset.
    assign alu_ready = reset_n & alu_valid & (~mem_valid | prio_q);
    assign mem_ready = reset_n & mem_valid & (~alu_valid | ~prio_q);
    assign xfer      = alu_ready | mem_ready;

    // Select the winning requester's payload for the output register.
    always_comb begin
        sel_rd   = mem_rd;
        sel_data = mem_data;
        if (alu_ready) begin
            sel_rd   = alu_rd;
            sel_data = alu_data;
        end
    end

    // Scoreboard next state: commit clears first, issue sets last so a newer producer wins.
    always_comb begin
        pending_nxt = pending;
        if (reg_write) begin
            pending_nxt[wr_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Registered write stage and round-robin pointer; rd=0 is accepted but never written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_write <= 1'b0;
            wr_rd     <= 5'd0;
            wr_data   <= '0;
            prio_q    <= 1'b0;
        end else if (xfer) begin
            reg_write <= (sel_rd != 5'd0);
            wr_rd     <= sel_rd;
            wr_data   <= sel_data;
            prio_q    <= ~alu_ready;
        end else begin
            reg_write <= 1'b0;
        end
    end

    // In-flight destination scoreboard.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 32'd0;
        end else begin
            pending <= pending_nxt;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: a reference model predicts grants, the write stream and the
// pending vector; a separate monitor pops expected writes as the DUT presents each output cycle.
module tb_wb_arbiter;

    logic        clk;
    logic        reset_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [63:0] mem_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        reg_write;
    logic [4:0]  wr_rd;
    logic [63:0] wr_data;
    logic [31:0] pending;

    wb_arbiter #(.XLEN(64)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .reg_write  (reg_write),
        .wr_rd      (wr_rd),
        .wr_data    (wr_data),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (spec-level view: who has priority, what is in flight, what will be written).
    logic        m_ptr;
    logic [31:0] m_pend;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [63:0] m_data;

    logic dut_ag, dut_mg;
    logic last_ea, last_em;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: every output cycle outside reset consumes one expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset_n && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("sb_reg_write", {63'd0, reg_write}, {63'd0, mon_e.we});
                if (mon_e.we) begin
                    check("sb_wr_rd", {59'd0, wr_rd}, {59'd0, mon_e.rd});
                    check("sb_wr_data", wr_data, mon_e.data);
                end
            end
        end
    end

    // Drive one cycle of requests, check grants/pending against the model, and queue the expected write.
    task automatic step(input logic av, input logic [4:0] ard, input logic [63:0] adat,
                        input logic mv, input logic [4:0] mrd, input logic [63:0] mdat,
                        input logic iv, input logic [4:0] ird);
        logic ea, em;
        logic [4:0] rd;
        exp_t e;
        @(negedge clk);
        alu_valid   = av;
        alu_rd      = ard;
        alu_data    = adat;
        mem_valid   = mv;
        mem_rd      = mrd;
        mem_data    = mdat;
        issue_valid = iv;
        issue_rd    = ird;
        #1;
        ea = av && (!mv || m_ptr);
        em = mv && (!av || !m_ptr);
        check("alu_ready", {63'd0, alu_ready}, {63'd0, ea});
        check("mem_ready", {63'd0, mem_ready}, {63'd0, em});
        check("pending", {32'd0, pending}, {32'd0, m_pend});
        dut_ag  = alu_ready;
        dut_mg  = mem_ready;
        last_ea = ea;
        last_em = em;
        // Upcoming edge: commit of the write currently on the port, then any new issue.
        if (m_we) m_pend[m_rd] = 1'b0;
        if (iv && ird != 5'd0) m_pend[ird] = 1'b1;
        if (ea || em) begin
            rd     = ea ? ard : mrd;
            m_data = ea ? adat : mdat;
            m_rd   = rd;
            m_we   = (rd != 5'd0);
            m_ptr  = ea ? 1'b0 : 1'b1;
        end else begin
            m_we = 1'b0;
        end
        e.we   = m_we;
        e.rd   = m_rd;
        e.data = m_data;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    endtask

    // Asynchronous reset between edges, with requests raised to show readies are forced low.
    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        alu_valid = 1'b1;
        mem_valid = 1'b1;
        #1;
        check("rst_reg_write", {63'd0, reg_write}, 64'd0);
        check("rst_wr_rd", {59'd0, wr_rd}, 64'd0);
        check("rst_wr_data", wr_data, 64'd0);
        check("rst_pending", {32'd0, pending}, 64'd0);
        check("rst_alu_ready", {63'd0, alu_ready}, 64'd0);
        check("rst_mem_ready", {63'd0, mem_ready}, 64'd0);
        alu_valid   = 1'b0;
        mem_valid   = 1'b0;
        issue_valid = 1'b0;
        exp_q.delete();
        m_ptr  = 1'b0;
        m_pend = 32'd0;
        m_we   = 1'b0;
        m_rd   = 5'd0;
        m_data = 64'd0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    logic        r_av, r_mv;
    logic [4:0]  r_ard, r_mrd;
    logic [63:0] r_adat, r_mdat;

    initial begin
        reset_n     = 1'b0;
        alu_valid   = 1'b0;
        alu_rd      = 5'd0;
        alu_data    = 64'd0;
        mem_valid   = 1'b0;
        mem_rd      = 5'd0;
        mem_data    = 64'd0;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        do_reset();

        // Single ALU request: same-cycle grant, one-cycle write, then quiet port with held address/data.
        step(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
        check("single_alu_ready", {63'd0, dut_ag}, 64'd1);
        after_edge();
        check("single_reg_write", {63'd0, reg_write}, 64'd1);
        check("single_wr_rd", {59'd0, wr_rd}, 64'd5);
        check("single_wr_data", wr_data, 64'h1234);
        idle();
        after_edge();
        check("single_quiet", {63'd0, reg_write}, 64'd0);
        check("hold_wr_rd", {59'd0, wr_rd}, 64'd5);
        check("hold_wr_data", wr_data, 64'h1234);

        // Contention from reset: MEM first, then strict alternation with a write every cycle.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22, 1'b0, 5'd0);
            check("contend_mem_grant", {63'd0, dut_mg}, {63'd0, (k % 2 == 0)});
            after_edge();
            check("contend_reg_write", {63'd0, reg_write}, 64'd1);
            check("contend_wr_rd", {59'd0, wr_rd}, (k % 2 == 0) ? 64'd2 : 64'd1);
        end

        // Write to x0: accepted but no register write, scoreboard untouched.
        do_reset();
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'h99, 1'b0, 5'd0);
        check("rd0_mem_ready", {63'd0, dut_mg}, 64'd1);
        after_edge();
        check("rd0_reg_write", {63'd0, reg_write}, 64'd0);
        check("rd0_pending", {32'd0, pending}, 64'd0);

        // Scoreboard: set on issue, clear on commit, same-edge reissue keeps the bit set.
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7);
        after_edge();
        check("pend7_set", {63'd0, pending[7]}, 64'd1);
        step(1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
        after_edge();
        check("pend7_write", {63'd0, reg_write}, 64'd1);
        idle();
        after_edge();
        check("pend7_cleared", {63'd0, pending[7]}, 64'd0);
        step(1'b1, 5'd7, 64'h78, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7);
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7);
        after_edge();
        check("pend7_reissue_wins", {63'd0, pending[7]}, 64'd1);
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0);
        after_edge();
        check("issue_x0_pend0", {63'd0, pending[0]}, 64'd0);

        // Stall hold: ALU loses to MEM, holds its request and wins next cycle.
        do_reset();
        step(1'b1, 5'd3, 64'hAA, 1'b1, 5'd4, 64'h55, 1'b0, 5'd0);
        check("stall_alu_ready", {63'd0, dut_ag}, 64'd0);
        step(1'b1, 5'd3, 64'hAA, 1'b1, 5'd4, 64'h56, 1'b0, 5'd0);
        check("stall_alu_grant", {63'd0, dut_ag}, 64'd1);
        after_edge();
        check("stall_wr_rd", {59'd0, wr_rd}, 64'd3);
        check("stall_wr_data", wr_data, 64'hAA);

        // Reset before commit discards the write and pending bits; pointer restarts at MEM.
        idle();
        step(1'b1, 5'd9, 64'h9, 1'b0, 5'd0, 64'd0, 1'b1, 5'd9);
        after_edge();
        check("flight_reg_write", {63'd0, reg_write}, 64'd1);
        check("flight_pend9", {63'd0, pending[9]}, 64'd1);
        do_reset();
        step(1'b1, 5'd1, 64'h1, 1'b1, 5'd2, 64'h2, 1'b0, 5'd0);
        check("post_reset_mem_first", {63'd0, dut_mg}, 64'd1);

        // Randomized traffic; a requester that was not granted keeps its request unchanged.
        r_av = 1'b0;
        r_mv = 1'b0;
        last_ea = 1'b0;
        last_em = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!(r_av && !last_ea)) begin
                r_av   = ($urandom_range(0, 3) != 0);
                r_ard  = 5'($urandom_range(0, 31));
                r_adat = {$urandom, $urandom};
            end
            if (!(r_mv && !last_em)) begin
                r_mv   = ($urandom_range(0, 3) != 0);
                r_mrd  = 5'($urandom_range(0, 31));
                r_mdat = {$urandom, $urandom};
            end
            step(r_av, r_ard, r_adat, r_mv, r_mrd, r_mdat,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            if (i % 1000 == 999) begin
                do_reset();
                r_av = 1'b0;
                r_mv = 1'b0;
                last_ea = 1'b0;
                last_em = 1'b0;
            end
        end
        idle();
        idle();
        after_edge();
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter XLEN, default 64, data width of the register-file write port.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 alu_valid  input  1  ALU writeback request valid.
REQ-005 alu_ready  output  1  ALU request accepted this cycle.
REQ-006 alu_rd  input  5  ALU destination register.
REQ-007 alu_data  input  XLEN  ALU result.
REQ-008 mem_valid  input  1  load writeback request valid.
REQ-009 mem_ready  output  1  load request accepted this cycle.
REQ-010 mem_rd  input  5  load destination register.
REQ-011 mem_data  input  XLEN  load result.
REQ-012 issue_valid  input  1  issue stage marks a new in-flight producer.
REQ-013 issue_rd  input  5  destination of the issued producer.
REQ-014 reg_write  output  1  register-file write enable.
REQ-015 wr_rd  output  5  register-file write address.
REQ-016 wr_data  output  XLEN  register-file write data.
REQ-017 pending  output  32  per-register in-flight scoreboard; bit 0 always 0.

Function
REQ-018 The block SHALL share the single register-file write port between ALU and MEM requesters using valid/ready; a transfer occurs when valid && ready on the same cycle.
REQ-019 alu_ready and mem_ready SHALL be combinational from the valids and the priority pointer; at most one is high per cycle; neither is high when its valid is low.
REQ-020 Only one valid high: that requester SHALL be granted the same cycle.
REQ-021 Both valid: grant SHALL go to the requester named by the 1-bit priority pointer (0=MEM, 1=ALU).
REQ-022 After any transfer the pointer SHALL point to the requester that did not win; without a transfer it SHALL hold.
REQ-023 A requester with valid high and ready low SHALL hold rd/data stable; the arbiter relies on this and does not capture unaccepted requests.
REQ-024 Output stage SHALL be registered: a transfer on edge N drives reg_write, wr_rd, wr_data during cycle N+1 (1-cycle latency); the regfile commits on edge N+1's following edge.
REQ-025 No transfer on an edge: reg_write SHALL be 0 the following cycle; wr_rd and wr_data hold previous values.
REQ-026 A transfer with rd=0 SHALL be consumed (ready high) but SHALL produce reg_write=0.
REQ-027 Throughput SHALL be one write per cycle, back-to-back, with no bubbles while any valid is high.
REQ-028 pending[issue_rd] SHALL set on the edge where issue_valid=1 and issue_rd!=0.
REQ-029 pending[wr_rd] SHALL clear on the edge where reg_write=1 (the regfile commit edge).
REQ-030 Set and clear of the same register on the same edge: set SHALL win (newer producer).
REQ-031 Set and clear of different registers on the same edge SHALL both take effect.
REQ-032 issue_valid with issue_rd=0 SHALL have no effect; pending[0] SHALL be constant 0.
REQ-033 A writeback to a register whose pending bit is 0 SHALL still write the regfile and leave the bit 0.

Reset
REQ-034 While reset_n=0: reg_write=0, wr_rd=0, wr_data=0, pending=0, priority pointer=0 (MEM first), independent of clk.
REQ-035 alu_ready and mem_ready SHALL be 0 while reset_n=0.
REQ-036 Reset asserted mid-operation SHALL discard the registered output write and all pending bits; first edge after release behaves as from power-on.

Verification
REQ-037 Single ALU: alu_valid=1, alu_rd=5, alu_data=0x1234 one cycle -> alu_ready=1 same cycle; next cycle reg_write=1, wr_rd=5, wr_data=0x1234; then reg_write=0.
REQ-038 Contention: both valid continuously after reset, alu_rd=1, mem_rd=2 -> grants MEM, ALU, MEM, ALU...; wr_rd sequence 2,1,2,1 with reg_write=1 every cycle.
REQ-039 rd=0: mem_valid=1, mem_rd=0 -> mem_ready=1, next cycle reg_write=0; pending unchanged.
REQ-040 Scoreboard: issue_rd=7 -> pending[7]=1; ALU writes rd=7 -> pending[7]=0 after the edge where reg_write=1; same-edge reissue of rd=7 with commit of rd=7 -> pending[7] remains 1.
REQ-041 Stall hold: both valid, ALU loses -> alu_ready=0, ALU holds alu_rd=3/data=0xAA; next cycle ALU granted and wr_data=0xAA appears one cycle later.
REQ-042 Reset mid-flight: transfer of rd=9 then reset_n=0 before commit -> reg_write=0, pending=0 immediately; after release pointer=MEM.
